// File: rtl/db_reg_bank_if.sv
// db_reg_bank_if: data-bus slave interface and window configuration type
package db_reg_bank_pkg;
  localparam logic [31:0] CFG_BADR_LED = 32'h0000_3000;
  localparam logic [31:0] CFG_MADR_LED = 32'hFFFF_FF00;
  typedef struct packed {
    logic [31:0] base_addr;
    logic [31:0] addr_mask;
  } bus_conf_t;
endpackage

interface db_reg_bank_if;
  logic req;
  logic we;
  logic [31:0] addr;
  logic [3:0] be;
  logic [31:0] wdata;
  logic gnt;
  logic rvalid;
  logic [31:0] rdata;
  logic err;
  db_reg_bank_pkg::bus_conf_t conf;
  modport master (output req, we, addr, be, wdata, input gnt, rvalid, rdata, err, conf);
  modport slave (input req, we, addr, be, wdata, output gnt, rvalid, rdata, err, conf);
endinterface

// File: rtl/db_reg_bank.sv
// db_reg_bank: byte-enable register bank with RO status slots, write strobes and error responses
module db_reg_bank
  import db_reg_bank_pkg::*;
#(
  parameter logic [31:0] base_addr = CFG_BADR_LED,
  parameter logic [31:0] addr_mask = CFG_MADR_LED,
  parameter int NUM_REGS = 4,
  parameter logic [NUM_REGS*32-1:0] REG_INIT = '0,
  parameter logic [NUM_REGS-1:0] RO_MASK = '0
) (
  input  logic clk,
  input  logic rst,
  output logic [NUM_REGS*32-1:0] reg_data_o,
  output logic [NUM_REGS-1:0] reg_wr_o,
  input  logic [NUM_REGS*32-1:0] status_i,
  db_reg_bank_if.slave dslv
);
  localparam int IDX_W = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;
  typedef enum logic {IDLE, ACCESS} state_t;
  state_t state, next;
  logic [IDX_W-1:0] idx;
  logic hit, ro;
  logic [31:0] rd_val, rdata_q;
  logic err_q;
  logic [NUM_REGS-1:0] wr_sel, wr_q;
  logic [31:0] regs [NUM_REGS];
  logic unused;
  assign idx = dslv.addr[2+:IDX_W];
  assign unused = ^{dslv.addr[1:0], dslv.addr[31:2+IDX_W], status_i};
  assign dslv.gnt = dslv.req;
  assign dslv.conf = '{base_addr, addr_mask};
  assign reg_wr_o = wr_q;
  always_comb begin
    hit = 1'b0;
    ro = 1'b0;
    rd_val = '0;
    wr_sel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      wr_sel[i] = dslv.req && dslv.we && !RO_MASK[i] && idx == IDX_W'(i);
      if (idx == IDX_W'(i)) begin
        hit = 1'b1;
        ro = RO_MASK[i];
        rd_val = RO_MASK[i] ? status_i[32*i+:32] : regs[i];
      end
    end
  end
  // Reset masks a pending response immediately, so no rvalid escapes a reset cycle
  always_comb begin
    next = dslv.req ? ACCESS : IDLE;
    dslv.rvalid = state == ACCESS && !rst;
    dslv.rdata = dslv.rvalid ? rdata_q : '0;
    dslv.err = dslv.rvalid && err_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rdata_q <= '0;
      err_q <= 1'b0;
      wr_q <= '0;
    end else begin
      state <= next;
      rdata_q <= dslv.req && !dslv.we && hit ? rd_val : '0;
      err_q <= dslv.req && (!hit || (dslv.we && ro));
      wr_q <= wr_sel;
    end
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rst)
        regs[i] <= REG_INIT[32*i+:32];
      else if (wr_sel[i])
        for (int b = 0; b < 4; b++)
          if (dslv.be[b]) regs[i][8*b+:8] <= dslv.wdata[8*b+:8];
    end
  end
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_out
    assign reg_data_o[32*i+:32] = RO_MASK[i] ? '0 : regs[i];
  end
endmodule

// File: tb/tb_db_reg_bank.sv
// tb_db_reg_bank: directed table-driven checks of two bank configurations
module tb_db_reg_bank;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [127:0] reg_a;
  logic [3:0] wr_a;
  logic [95:0] reg_b;
  logic [2:0] wr_b;
  logic [127:0] stat_a = {32'h1234_5678, 32'hBAD0_0002, 32'hBAD0_0001, 32'hBAD0_0000};
  logic [95:0] stat_b = {32'hBAD1_0002, 32'hBAD1_0001, 32'hBAD1_0000};
  int n_chk = 0;
  int n_fail = 0;
  db_reg_bank_if ba();
  db_reg_bank_if bb();
  db_reg_bank #(.NUM_REGS(4), .REG_INIT({96'h0, 32'hA5A5_0001}), .RO_MASK(4'b1000)) ua (
    .clk(clk), .rst(rst), .reg_data_o(reg_a), .reg_wr_o(wr_a), .status_i(stat_a), .dslv(ba));
  db_reg_bank #(.NUM_REGS(3)) ub (
    .clk(clk), .rst(rst), .reg_data_o(reg_b), .reg_wr_o(wr_b), .status_i(stat_b), .dslv(bb));
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  typedef struct {
    bit sel;
    bit we;
    logic [31:0] addr;
    logic [3:0] be;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    bit exp_err;
    logic [3:0] exp_wr;
    int slot;
    logic [31:0] exp_slot;
  } vec_t;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic drive(input bit s, input bit req, input bit we, input logic [31:0] addr,
                       input logic [3:0] be, input logic [31:0] wdata);
    if (s) begin
      bb.req = req; bb.we = we; bb.addr = addr; bb.be = be; bb.wdata = wdata;
    end else begin
      ba.req = req; ba.we = we; ba.addr = addr; ba.be = be; ba.wdata = wdata;
    end
  endtask
  function automatic logic rv(bit s);
    return s ? bb.rvalid : ba.rvalid;
  endfunction
  function automatic logic [31:0] rd(bit s);
    return s ? bb.rdata : ba.rdata;
  endfunction
  function automatic logic er(bit s);
    return s ? bb.err : ba.err;
  endfunction
  function automatic logic gn(bit s);
    return s ? bb.gnt : ba.gnt;
  endfunction
  function automatic logic [3:0] wr(bit s);
    return s ? {1'b0, wr_b} : wr_a;
  endfunction
  function automatic logic [31:0] slot(bit s, int i);
    return s ? reg_b[32*i+:32] : reg_a[32*i+:32];
  endfunction
  task automatic do_vec(input vec_t v, input int k);
    @(negedge clk);
    chk($sformatf("v%0d idle_rvalid", k), 32'(rv(v.sel)), 32'h0);
    chk($sformatf("v%0d idle_rdata", k), rd(v.sel), 32'h0);
    drive(v.sel, 1'b1, v.we, v.addr, v.be, v.wdata);
    #1;
    chk($sformatf("v%0d gnt", k), 32'(gn(v.sel)), 32'h1);
    @(negedge clk);
    drive(v.sel, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    #1;
    chk($sformatf("v%0d rvalid", k), 32'(rv(v.sel)), 32'h1);
    chk($sformatf("v%0d rdata", k), rd(v.sel), v.exp_rdata);
    chk($sformatf("v%0d err", k), 32'(er(v.sel)), 32'(v.exp_err));
    chk($sformatf("v%0d reg_wr", k), 32'(wr(v.sel)), 32'(v.exp_wr));
    chk($sformatf("v%0d slot%0d", k, v.slot), slot(v.sel, v.slot), v.exp_slot);
  endtask
  vec_t vecs [15];
  logic [31:0] b2b_rd [4];
  initial begin
    vecs[0]  = '{0, 0, 32'h00, 4'h0, 32'h0,         32'hA5A5_0001, 0, 4'b0000, 0, 32'hA5A5_0001};
    vecs[1]  = '{0, 1, 32'h04, 4'h5, 32'hDEAD_BEEF, 32'h0,         0, 4'b0010, 1, 32'h00AD_00EF};
    vecs[2]  = '{0, 0, 32'h04, 4'h0, 32'h0,         32'h00AD_00EF, 0, 4'b0000, 1, 32'h00AD_00EF};
    vecs[3]  = '{0, 1, 32'h04, 4'hA, 32'h1122_3344, 32'h0,         0, 4'b0010, 1, 32'h11AD_33EF};
    vecs[4]  = '{0, 1, 32'h08, 4'h0, 32'hFFFF_FFFF, 32'h0,         0, 4'b0100, 2, 32'h0};
    vecs[5]  = '{0, 0, 32'h0C, 4'h0, 32'h0,         32'h1234_5678, 0, 4'b0000, 3, 32'h0};
    vecs[6]  = '{0, 1, 32'h0C, 4'hF, 32'hFFFF_FFFF, 32'h0,         1, 4'b0000, 3, 32'h0};
    vecs[7]  = '{0, 0, 32'h0F, 4'h0, 32'h0,         32'h1234_5678, 0, 4'b0000, 3, 32'h0};
    vecs[8]  = '{0, 1, 32'h03, 4'h1, 32'h0000_00FF, 32'h0,         0, 4'b0001, 0, 32'hA5A5_00FF};
    vecs[9]  = '{0, 0, 32'h10, 4'h0, 32'h0,         32'hA5A5_00FF, 0, 4'b0000, 0, 32'hA5A5_00FF};
    vecs[10] = '{1, 1, 32'h08, 4'hF, 32'h7777_7777, 32'h0,         0, 4'b0100, 2, 32'h7777_7777};
    vecs[11] = '{1, 0, 32'h0C, 4'h0, 32'h0,         32'h0,         1, 4'b0000, 2, 32'h7777_7777};
    vecs[12] = '{1, 1, 32'h0C, 4'hF, 32'hDEAD_0000, 32'h0,         1, 4'b0000, 2, 32'h7777_7777};
    vecs[13] = '{1, 0, 32'h08, 4'h0, 32'h0,         32'h7777_7777, 0, 4'b0000, 0, 32'h0};
    vecs[14] = '{0, 0, 32'h04, 4'h0, 32'h0,         32'h11AD_33EF, 0, 4'b0000, 1, 32'h11AD_33EF};
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("rst rvalid", 32'(ba.rvalid), 32'h0);
    rst = 1'b0;
    #1;
    chk("rst slot0", reg_a[31:0], 32'hA5A5_0001);
    chk("rst slot3 ro", reg_a[127:96], 32'h0);
    chk("rst reg_wr", 32'(wr_a), 32'h0);
    chk("rst rdata", ba.rdata, 32'h0);
    chk("rst err", 32'(ba.err), 32'h0);
    chk("rst b regs", reg_b[31:0] | reg_b[63:32] | reg_b[95:64], 32'h0);
    chk("conf base", ba.conf.base_addr, 32'h0000_3000);
    chk("conf mask", ba.conf.addr_mask, 32'hFFFF_FF00);
    for (int k = 0; k < 15; k++) do_vec(vecs[k], k);
    chk("b illegal no change lo", reg_b[63:0] == 64'h0 ? 32'h1 : 32'h0, 32'h1);
    // write, write, read, read with req held high
    b2b_rd = '{32'h0, 32'h0, 32'hCAFE_F00D, 32'h0BAD_CAFE};
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      if (k > 0) begin
        chk($sformatf("b2b%0d rvalid", k), 32'(ba.rvalid), 32'h1);
        chk($sformatf("b2b%0d rdata", k), ba.rdata, b2b_rd[k-1]);
        chk($sformatf("b2b%0d err", k), 32'(ba.err), 32'h0);
        chk($sformatf("b2b%0d reg_wr", k), 32'(wr_a), k == 1 ? 32'h2 : k == 2 ? 32'h4 : 32'h0);
      end
      case (k)
        0: drive(0, 1, 1, 32'h04, 4'hF, 32'hCAFE_F00D);
        1: drive(0, 1, 1, 32'h08, 4'hF, 32'h0BAD_CAFE);
        2: drive(0, 1, 0, 32'h04, 4'h0, 32'h0);
        3: drive(0, 1, 0, 32'h08, 4'h0, 32'h0);
        default: drive(0, 0, 0, 32'h0, 4'h0, 32'h0);
      endcase
      #1;
      if (k < 4) chk($sformatf("b2b%0d gnt", k), 32'(ba.gnt), 32'h1);
    end
    @(negedge clk);
    chk("b2b tail rvalid", 32'(ba.rvalid), 32'h0);
    // granted read, then reset plus a write in the following cycle
    drive(0, 1, 0, 32'h04, 4'h0, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    drive(0, 1, 1, 32'h00, 4'hF, 32'hFFFF_FFFF);
    #1;
    chk("mid rst rvalid", 32'(ba.rvalid), 32'h0);
    chk("mid rst rdata", ba.rdata, 32'h0);
    chk("mid rst err", 32'(ba.err), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 32'h0, 4'h0, 32'h0);
    #1;
    chk("post rst rvalid", 32'(ba.rvalid), 32'h0);
    chk("post rst slot0", reg_a[31:0], 32'hA5A5_0001);
    chk("post rst slot1", reg_a[63:32], 32'h0);
    chk("post rst slot2", reg_a[95:64], 32'h0);
    chk("post rst reg_wr", 32'(wr_a), 32'h0);
    do_vec('{0, 0, 32'h00, 4'h0, 32'h0, 32'hA5A5_0001, 0, 4'b0000, 0, 32'hA5A5_0001}, 99);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
